// File: rtl/instr_fetch_seq.sv
`timescale 1ns/1ps
// instr_fetch_seq: program counter owner and instruction fetch sequencer.
// It fetches one byte per instruction over a req/valid handshake and presents
// opcode/operand to the control unit. The control unit's jump decision and the
// datapath's jump target select the next PC.
//
// state | meaning
// IDLE  | post-reset bubble, outputs inactive
// FETCH | mem_req high at mem_addr=pc, waiting for mem_valid
// ISSUE | instr_valid high, opcode/operand live, waits for stall=0
// HALT  | HALT_OP retired, sequencer parked until reset
module instr_fetch_seq #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HALT_OP  = 4'b1111
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_valid,
    output logic [3:0]        opcode,
    output logic [3:0]        operand,
    output logic              instr_valid,
    input  logic              jmp_enable,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              stall,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic [3:0]        opcode_nxt;
    logic [3:0]        operand_nxt;

    // The fetch address is always the PC; no separate address register.
    assign mem_addr = pc;

    // State, PC and instruction registers; reset forces IDLE so mem_req drops at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            opcode  <= 4'd0;
            operand <= 4'd0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            opcode  <= opcode_nxt;
            operand <= operand_nxt;
        end
    end

    // Next-state, next-PC and Moore outputs decoded from the current state.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        opcode_nxt  = opcode;
        operand_nxt = operand;
        mem_req     = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                mem_req = 1'b1;
                if (mem_valid) begin
                    opcode_nxt  = mem_rdata[7:4];
                    operand_nxt = mem_rdata[3:0];
                    state_nxt   = ISSUE;
                end
            end
            ISSUE: begin
                instr_valid = 1'b1;
                // jmp_enable only matters on the edge that actually retires the instruction.
                if (!stall) begin
                    if (opcode == HALT_OP) begin
                        state_nxt = HALT;
                    end else begin
                        pc_nxt    = jmp_enable ? jmp_target : pc + ADDR_W'(1);
                        state_nxt = FETCH;
                    end
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_seq.sv
`timescale 1ns/1ps
// Directed bench for instr_fetch_seq with a behavioural memory, a cycle model
// and an instruction scoreboard fed at the memory-accept edge.
module tb_instr_fetch_seq;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_valid = 1'b0;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic       instr_valid;
    logic       jmp_enable = 1'b0;
    logic [7:0] jmp_target = 8'h00;
    logic       stall = 1'b0;
    logic [7:0] pc;
    logic       halted;

    always #5 clk = ~clk;

    instr_fetch_seq #(.ADDR_W(8), .RESET_PC(8'h00), .HALT_OP(4'b1111)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_valid  (mem_valid),
        .opcode     (opcode),
        .operand    (operand),
        .instr_valid(instr_valid),
        .jmp_enable (jmp_enable),
        .jmp_target (jmp_target),
        .stall      (stall),
        .pc         (pc),
        .halted     (halted)
    );

    logic [7:0]  mem [0:255];
    logic [15:0] sb [$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          wait_left = 0;
    bit          auto_mem = 1'b1;

    logic [1:0] m_state;
    logic [7:0] m_pc;
    logic [3:0] m_op;
    logic [3:0] m_opd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_pc    = 8'h00;
        m_op    = 4'h0;
        m_opd   = 4'h0;
        sb.delete();
    endtask

    task automatic respond();
        if (auto_mem) begin
            if (mem_req) begin
                if (wait_left > 0) begin
                    mem_valid = 1'b0;
                    mem_rdata = 8'hA5;
                    wait_left--;
                end else begin
                    mem_valid = 1'b1;
                    mem_rdata = mem[mem_addr];
                end
            end else begin
                mem_valid = 1'b0;
                mem_rdata = 8'hA5;
            end
        end
    endtask

    task automatic check_outputs();
        chk("mem_req", 32'(mem_req), 32'(m_state == S_FETCH));
        chk("mem_addr", 32'(mem_addr), 32'(m_pc));
        chk("pc", 32'(pc), 32'(m_pc));
        chk("instr_valid", 32'(instr_valid), 32'(m_state == S_ISSUE));
        chk("halted", 32'(halted), 32'(m_state == S_HALT));
        chk("opcode", 32'(opcode), 32'(m_op));
        chk("operand", 32'(operand), 32'(m_opd));
        if (instr_valid) begin
            chk("sb_depth", 32'(sb.size()), 32'd1);
            if (sb.size() > 0) chk("sb_instr", {16'h0, opcode, operand, pc}, {16'h0, sb[0]});
        end
    endtask

    // One clock: advance the model with the inputs present at the edge, then compare.
    task automatic tick();
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            model_reset();
        end else begin
            case (m_state)
                S_IDLE: m_state = S_FETCH;
                S_FETCH: begin
                    if (mem_valid) begin
                        m_op  = mem_rdata[7:4];
                        m_opd = mem_rdata[3:0];
                        sb.push_back({mem_rdata, m_pc});
                        m_state = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!stall) begin
                        if (sb.size() > 0) void'(sb.pop_front());
                        if (m_op == 4'hF) begin
                            m_state = S_HALT;
                        end else begin
                            m_pc    = jmp_enable ? jmp_target : m_pc + 8'd1;
                            m_state = S_FETCH;
                        end
                    end
                end
                default: m_state = S_HALT;
            endcase
        end
        #1;
        check_outputs();
        respond();
    endtask

    task automatic wait_issue(input int max, output int req_cycles);
        req_cycles = 0;
        for (int i = 0; i < max && !instr_valid; i++) begin
            if (mem_req) req_cycles++;
            tick();
        end
        chk("issue_timeout", 32'(instr_valid), 32'd1);
    endtask

    initial begin
        int         rc;
        int         iv_cnt;
        int         hcnt;
        int         issue_cyc [3];
        logic [3:0] exp_op  [3];
        logic [3:0] exp_opd [3];

        exp_op  = '{4'h6, 4'h5, 4'h7};
        exp_opd = '{4'h1, 4'h2, 4'h3};
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        mem[8'h00] = 8'h61;
        mem[8'h01] = 8'h52;
        mem[8'h02] = 8'h73;
        mem[8'h03] = 8'h44;
        mem[8'h04] = 8'h35;
        mem[8'h05] = 8'hD0;
        mem[8'h20] = 8'hD1;
        mem[8'h10] = 8'hD0;
        mem[8'h11] = 8'hA5;
        mem[8'hFF] = 8'h37;
        mem[8'h30] = 8'hF0;

        // Reset values
        model_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_pc", 32'(pc), 32'h00);
        chk("rst_req", 32'(mem_req), 32'd0);
        #3 rst_n = 1'b1;

        // Zero-wait fetch of three instructions, two cycles each
        for (int k = 0; k < 3; k++) begin
            wait_issue(10, rc);
            chk("t1_op", 32'(opcode), 32'(exp_op[k]));
            chk("t1_opd", 32'(operand), 32'(exp_opd[k]));
            chk("t1_pc", 32'(pc), k);
            issue_cyc[k] = cyc;
            jmp_enable = 1'b0;
            tick();
        end
        chk("t1_cpi_a", issue_cyc[1] - issue_cyc[0], 2);
        chk("t1_cpi_b", issue_cyc[2] - issue_cyc[1], 2);

        // Three memory wait states at addr 4
        wait_issue(10, rc);
        chk("t2_pc3", 32'(pc), 32'h03);
        wait_left = 3;
        tick();
        wait_issue(20, rc);
        chk("t2_req_cycles", rc, 4);
        chk("t2_pc", 32'(pc), 32'h04);
        chk("t2_op", 32'(opcode), 32'h3);
        tick();

        // Jump taken, then not taken
        wait_issue(10, rc);
        chk("t3_op", 32'(opcode), 32'hD);
        jmp_enable = 1'b1; jmp_target = 8'h20;
        tick();
        jmp_enable = 1'b0;
        chk("t3_jmp_addr", 32'(mem_addr), 32'h20);
        wait_issue(10, rc);
        jmp_enable = 1'b1; jmp_target = 8'h10;
        tick();
        jmp_enable = 1'b0;
        chk("t3_jmp_addr2", 32'(mem_addr), 32'h10);
        wait_issue(10, rc);
        tick();
        chk("t3_nojmp_addr", 32'(mem_addr), 32'h11);

        // Stall for two cycles with jmp_enable toggling
        wait_issue(10, rc);
        iv_cnt = 0;
        stall = 1'b1; jmp_enable = 1'b1; jmp_target = 8'h40;
        iv_cnt += int'(instr_valid);
        tick();
        jmp_enable = 1'b0; jmp_target = 8'h41;
        iv_cnt += int'(instr_valid);
        tick();
        chk("t4_hold_op", 32'(opcode), 32'hA);
        chk("t4_hold_pc", 32'(pc), 32'h11);
        stall = 1'b0; jmp_enable = 1'b1; jmp_target = 8'hFF;
        iv_cnt += int'(instr_valid);
        tick();
        jmp_enable = 1'b0;
        chk("t4_iv_cycles", iv_cnt, 3);
        chk("t4_next_addr", 32'(mem_addr), 32'hFF);

        // PC wrap, then halt
        wait_issue(10, rc);
        tick();
        chk("t5_wrap_addr", 32'(mem_addr), 32'h00);
        wait_issue(10, rc);
        jmp_enable = 1'b1; jmp_target = 8'h30;
        tick();
        jmp_enable = 1'b0;
        wait_issue(10, rc);
        chk("t5_halt_op", 32'(opcode), 32'hF);
        jmp_enable = 1'b1; jmp_target = 8'h55;
        tick();
        jmp_enable = 1'b0;
        auto_mem = 1'b0; mem_valid = 1'b1; mem_rdata = 8'h11;
        hcnt = 0;
        for (int i = 0; i < 20; i++) begin
            stall = 1'($urandom_range(0, 1));
            jmp_enable = 1'($urandom_range(0, 1));
            tick();
            if (halted && !mem_req && !instr_valid) hcnt++;
        end
        stall = 1'b0; jmp_enable = 1'b0;
        chk("t5_halt_cycles", hcnt, 20);
        chk("t5_halt_pc", 32'(pc), 32'h30);

        // Asynchronous reset mid-fetch, stray mem_valid in IDLE
        auto_mem = 1'b1; mem_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        repeat (2) tick();
        #3 rst_n = 1'b1;
        wait_left = 50;
        tick();
        tick();
        #3;
        chk("t6_req_before", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_req", 32'(mem_req), 32'd0);
        chk("t6_async_pc", 32'(pc), 32'h00);
        model_reset();
        wait_left = 0;
        auto_mem = 1'b0; mem_valid = 1'b1; mem_rdata = 8'hEE;
        repeat (2) tick();
        #3 rst_n = 1'b1;
        tick();
        chk("t6_stray_iv", 32'(instr_valid), 32'd0);
        chk("t6_fetch_req", 32'(mem_req), 32'd1);
        chk("t6_fetch_addr", 32'(mem_addr), 32'h00);
        auto_mem = 1'b1;
        respond();
        wait_issue(10, rc);
        chk("t6_op", 32'(opcode), 32'h6);
        chk("t6_opd", 32'(operand), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
